// File: rtl/ravenoc_axi_wr_arb.sv
// Round-robin arbiter that shares one RaveNoC AXI write port among N_REQ local masters,
// running one complete AW / W burst / B transaction per grant.
module ravenoc_axi_wr_arb #(
   parameter int N_REQ  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic                      clk_axi,
   input  logic                      arst_axi,
   input  logic [N_REQ-1:0]          req_awvalid,
   input  logic [N_REQ*ADDR_W-1:0]   req_awaddr,
   input  logic [N_REQ*LEN_W-1:0]    req_awlen,
   output logic [N_REQ-1:0]          req_awready,
   input  logic [N_REQ-1:0]          req_wvalid,
   input  logic [N_REQ*DATA_W-1:0]   req_wdata,
   input  logic [N_REQ-1:0]          req_wlast,
   output logic [N_REQ-1:0]          req_wready,
   output logic [N_REQ-1:0]          req_bvalid,
   output logic [1:0]                req_bresp,
   input  logic [N_REQ-1:0]          req_bready,
   output logic                      m_awvalid,
   input  logic                      m_awready,
   output logic [ADDR_W-1:0]         m_awaddr,
   output logic [LEN_W-1:0]          m_awlen,
   output logic                      m_wvalid,
   input  logic                      m_wready,
   output logic [DATA_W-1:0]         m_wdata,
   output logic                      m_wlast,
   input  logic                      m_bvalid,
   output logic                      m_bready,
   input  logic [1:0]                m_bresp,
   output logic [N_REQ-1:0]          grant,
   output logic                      wlast_err
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t            state, next_state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  owner;
   logic [IDX_W-1:0]  win_idx;
   logic [IDX_W-1:0]  cand;
   logic              win_found;
   logic [LEN_W-1:0]  beat_cnt;
   logic              aw_hs, w_hs, b_hs;

   // Search starts just after the last owner, so the last owner has lowest priority.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (!win_found && req_awvalid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      next_state  = state;
      req_awready = '0;
      req_wready  = '0;
      req_bvalid  = '0;
      req_bresp   = '0;
      m_awvalid   = 1'b0;
      m_awaddr    = '0;
      m_awlen     = '0;
      m_wvalid    = 1'b0;
      m_wdata     = '0;
      m_wlast     = 1'b0;
      m_bready    = 1'b0;
      aw_hs       = 1'b0;
      w_hs        = 1'b0;
      b_hs        = 1'b0;
      case (state)
         IDLE: begin
            if (win_found) next_state = ADDR;
         end
         ADDR: begin
            m_awvalid          = req_awvalid[owner];
            m_awaddr           = req_awaddr[int'(owner)*ADDR_W +: ADDR_W];
            m_awlen            = req_awlen[int'(owner)*LEN_W +: LEN_W];
            req_awready[owner] = m_awready;
            aw_hs              = m_awvalid && m_awready;
            if (aw_hs) next_state = DATA;
         end
         DATA: begin
            m_wvalid          = req_wvalid[owner];
            m_wdata           = req_wdata[int'(owner)*DATA_W +: DATA_W];
            m_wlast           = (beat_cnt == '0);
            req_wready[owner] = m_wready;
            w_hs              = m_wvalid && m_wready;
            if (w_hs && m_wlast) next_state = RESP;
         end
         RESP: begin
            req_bvalid[owner] = m_bvalid;
            req_bresp         = m_bresp;
            m_bready          = req_bready[owner];
            b_hs              = m_bvalid && m_bready;
            if (b_hs) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_axi or negedge arst_axi) begin
      if (!arst_axi) state <= IDLE;
      else           state <= next_state;
   end

   always_ff @(posedge clk_axi or negedge arst_axi) begin
      if (!arst_axi) begin
         rr_ptr    <= IDX_W'(N_REQ - 1);
         owner     <= '0;
         grant     <= '0;
         beat_cnt  <= '0;
         wlast_err <= 1'b0;
      end else begin
         if (state == IDLE && win_found) begin
            owner <= win_idx;
            grant <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
         end
         if (aw_hs) beat_cnt <= m_awlen;
         // The burst length comes from the latched awlen; the requester's wlast is only audited.
         if (w_hs) begin
            if (beat_cnt != '0) beat_cnt <= beat_cnt - LEN_W'(1);
            if (req_wlast[owner] != m_wlast) wlast_err <= 1'b1;
         end
         if (b_hs) begin
            rr_ptr <= owner;
            grant  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ravenoc_axi_wr_arb.sv
// Self-checking bench for ravenoc_axi_wr_arb: behavioural masters, a NoC slave model and a
// round-robin reference compared against the DUT every cycle, plus directed end-of-test checks.
module tb_ravenoc_axi_wr_arb;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;

   logic              clk_axi = 1'b0;
   logic              arst_axi = 1'b0;
   logic [N-1:0]      req_awvalid, req_awready, req_wvalid, req_wlast, req_wready;
   logic [N-1:0]      req_bvalid, req_bready, grant;
   logic [N*AW-1:0]   req_awaddr;
   logic [N*LW-1:0]   req_awlen;
   logic [N*DW-1:0]   req_wdata;
   logic [1:0]        req_bresp, m_bresp;
   logic              m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
   logic [AW-1:0]     m_awaddr;
   logic [LW-1:0]     m_awlen;
   logic [DW-1:0]     m_wdata;
   logic              wlast_err;

   ravenoc_axi_wr_arb #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk_axi(clk_axi), .arst_axi(arst_axi),
      .req_awvalid(req_awvalid), .req_awaddr(req_awaddr), .req_awlen(req_awlen),
      .req_awready(req_awready), .req_wvalid(req_wvalid), .req_wdata(req_wdata),
      .req_wlast(req_wlast), .req_wready(req_wready), .req_bvalid(req_bvalid),
      .req_bresp(req_bresp), .req_bready(req_bready),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wlast(m_wlast),
      .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
      .grant(grant), .wlast_err(wlast_err)
   );

   always #5 clk_axi = ~clk_axi;

   int n_checks = 0;
   int n_err    = 0;

   // Requester models
   bit          mst_active[N];
   bit          mst_aw_done[N];
   int          mst_wbeat[N];
   int          mst_len[N];
   int          mst_bad[N];
   int          mst_left[N];
   int          mst_req_cyc[N];
   logic [AW-1:0] mst_addr[N];
   logic [DW-1:0] mst_base[N];

   // NoC slave model and arbitration reference
   int          sl_beats, sl_len;
   bit          sl_bpend;
   logic [1:0]  sl_bresp;
   int          exp_ptr, exp_owner;
   bit          arb_chk, exp_err, chk_lat;
   bit          rand_aw, rand_w, rand_b;
   int          order[$];
   int          last_beats, cyc;
   logic [1:0]  last_bresp;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] beat_data(input int i, input int b);
      return mst_base[i] + DW'(b);
   endfunction

   task automatic arm(input int i, input int len, input logic [AW-1:0] addr, input int n, input int bad);
      mst_active[i]  = 1'b1;
      mst_aw_done[i] = 1'b0;
      mst_wbeat[i]   = 0;
      mst_len[i]     = len;
      mst_addr[i]    = addr;
      mst_base[i]    = $urandom;
      mst_bad[i]     = bad;
      mst_left[i]    = n;
      mst_req_cyc[i] = -1;
   endtask

   function automatic bit all_done();
      bit busy = (exp_owner >= 0);
      for (int i = 0; i < N; i++) busy |= mst_active[i];
      return !busy;
   endfunction

   task automatic step();
      int o;
      bit w_m, w_r, b_m, b_r;
      @(negedge clk_axi);
      cyc++;
      for (int i = 0; i < N; i++) begin
         req_awvalid[i] = mst_active[i] && !mst_aw_done[i];
         if (req_awvalid[i] && mst_req_cyc[i] < 0) mst_req_cyc[i] = cyc;
         req_awaddr[i*AW +: AW] = mst_addr[i];
         req_awlen[i*LW +: LW]  = LW'(mst_len[i]);
         req_wvalid[i]          = mst_active[i] && (mst_wbeat[i] <= mst_len[i]);
         req_wdata[i*DW +: DW]  = beat_data(i, mst_wbeat[i]);
         req_wlast[i]           = (mst_wbeat[i] == mst_len[i]) ^ (mst_wbeat[i] == mst_bad[i]);
         req_bready[i]          = rand_b ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      m_awready = rand_aw ? 1'($urandom_range(0, 1)) : 1'b1;
      m_wready  = rand_w  ? 1'($urandom_range(0, 1)) : 1'b1;
      m_bvalid  = sl_bpend;
      m_bresp   = sl_bresp;
      #1;
      check("nongrant_ready", (req_awready | req_wready | req_bvalid) & ~grant, '0);
      check("grant_onehot0", $onehot0(grant), 1);
      if (arb_chk) begin
         check("grant", grant, N'(1) << exp_owner);
         arb_chk = 1'b0;
      end else if (exp_owner < 0) begin
         check("idle_grant", grant, '0);
         check("idle_fwd", {m_awvalid, m_wvalid, m_bready}, '0);
         if (|req_awvalid) begin
            for (int k = 1; k <= N; k++) begin
               if (exp_owner < 0 && req_awvalid[(exp_ptr + k) % N]) exp_owner = (exp_ptr + k) % N;
            end
            arb_chk = 1'b1;
         end
      end
      if (exp_owner >= 0 && !arb_chk) begin
         o   = exp_owner;
         w_m = m_wvalid && m_wready;
         w_r = req_wvalid[o] && req_wready[o];
         check("w_hs_pair", w_r, w_m);
         if (w_m) begin
            check("w_in_burst", mst_aw_done[o] && sl_beats <= sl_len, 1);
            check("wdata", m_wdata, beat_data(o, sl_beats));
            check("wlast", m_wlast, sl_beats == sl_len);
            sl_beats++;
            if (sl_beats == sl_len + 1) sl_bpend = 1'b1;
         end
         if (w_r) begin
            if (mst_wbeat[o] == mst_bad[o]) exp_err = 1'b1;
            mst_wbeat[o]++;
         end
         if (m_awvalid && m_awready) begin
            check("awaddr", m_awaddr, mst_addr[o]);
            check("awlen", m_awlen, mst_len[o]);
            check("awready_owner", req_awready[o], 1);
            if (chk_lat) check("aw_latency", cyc - mst_req_cyc[o], 1);
            mst_aw_done[o] = 1'b1;
            sl_len   = int'(m_awlen);
            sl_beats = 0;
         end
         b_m = m_bvalid && m_bready;
         b_r = req_bvalid[o] && req_bready[o];
         check("b_hs_pair", b_r, b_m);
         if (b_r) begin
            check("bresp", req_bresp, sl_bresp);
            check("beats", sl_beats, mst_len[o] + 1);
            check("wlast_err", wlast_err, exp_err);
            last_beats = sl_beats;
            last_bresp = req_bresp;
            order.push_back(o);
            sl_bpend  = 1'b0;
            exp_ptr   = o;
            exp_owner = -1;
            if (mst_left[o] > 1) begin
               mst_left[o]--;
               mst_aw_done[o] = 1'b0;
               mst_wbeat[o]   = 0;
               mst_base[o]    = $urandom;
               mst_req_cyc[o] = -1;
            end else begin
               mst_active[o] = 1'b0;
            end
         end
      end
   endtask

   task automatic run(input int budget);
      int n = 0;
      while (!all_done() && n < budget) begin
         step();
         n++;
      end
      check("finished", all_done(), 1);
      step();
   endtask

   task automatic do_reset();
      arst_axi    = 1'b0;
      req_awvalid = '0; req_awaddr = '0; req_awlen = '0; req_wvalid = '0;
      req_wdata   = '0; req_wlast  = '0; req_bready = '0;
      m_awready   = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
      for (int i = 0; i < N; i++) begin
         mst_active[i] = 1'b0; mst_aw_done[i] = 1'b0; mst_wbeat[i] = 0; mst_len[i] = 0;
         mst_bad[i] = -1; mst_left[i] = 0; mst_req_cyc[i] = -1; mst_addr[i] = '0; mst_base[i] = '0;
      end
      sl_beats = 0; sl_len = 0; sl_bpend = 1'b0; sl_bresp = '0;
      exp_ptr = N - 1; exp_owner = -1; arb_chk = 1'b0; exp_err = 1'b0; chk_lat = 1'b0;
      rand_aw = 1'b0; rand_w = 1'b0; rand_b = 1'b0;
      order.delete();
      repeat (2) @(negedge clk_axi);
      #1;
      check("rst_grant", grant, '0);
      check("rst_wlast_err", wlast_err, 0);
      check("rst_m_out", {m_awvalid, m_wvalid, m_wlast, m_bready}, '0);
      check("rst_req_out", {req_awready, req_wready, req_bvalid}, '0);
      @(negedge clk_axi);
      arst_axi = 1'b1;
   endtask

   initial begin
      int exp_ord[5] = '{0, 1, 2, 3, 0};
      int n;
      cyc = 0;
      do_reset();

      // Single requester, all NoC readies tied high
      chk_lat = 1'b1;
      arm(0, 3, 32'h0000_1000, 1, -1);
      run(100);
      chk_lat = 1'b0;
      check("t1_owner", order[0], 0);
      check("t1_beats", last_beats, 4);
      check("t1_grant_idle", grant, '0);

      // All four requesters with single-beat bursts held valid
      do_reset();
      arm(0, 0, 32'h0000_2000, 2, -1);
      for (int i = 1; i < N; i++) arm(i, 0, 32'h0000_2000 + AW'(i * 16), 1, -1);
      run(200);
      check("t2_count", order.size(), 5);
      for (int i = 0; i < 5; i++) check($sformatf("t2_order%0d", i), order[i], exp_ord[i]);

      // Randomized NoC readies on an 8-beat burst
      rand_aw = 1'b1; rand_w = 1'b1; rand_b = 1'b1;
      sl_bresp = 2'($urandom_range(0, 3));
      arm(1, 7, $urandom, 1, -1);
      run(300);
      check("t3_beats", last_beats, 8);

      // Requester 2 flags wlast early; requester 3 follows
      order.delete();
      arm(2, 2, $urandom, 1, 1);
      arm(3, 1, $urandom, 1, -1);
      run(300);
      check("t4_first", order[0], 2);
      check("t4_second", order[1], 3);
      check("t4_err_sticky", wlast_err, 1);

      // Reset in the middle of a data burst
      do_reset();
      arm(0, 5, 32'h0000_5000, 1, -1);
      n = 0;
      while (mst_wbeat[0] < 2 && n < 50) begin
         step();
         n++;
      end
      @(posedge clk_axi);
      #1;
      check("t5_pre_wvalid", m_wvalid, 1);
      arst_axi = 1'b0;
      #1;
      check("t5_rst_wvalid", m_wvalid, 0);
      check("t5_rst_grant", grant, '0);
      do_reset();
      arm(0, 1, 32'h0000_6000, 1, -1);
      arm(3, 1, 32'h0000_6100, 1, -1);
      run(100);
      check("t5_first", order[0], 0);
      check("t5_second", order[1], 3);

      // Maximum burst length with an error response
      sl_bresp = 2'b10;
      order.delete();
      arm(0, 255, 32'h0000_7000, 1, -1);
      run(600);
      check("t6_beats", last_beats, 256);
      check("t6_bresp", last_bresp, 2'b10);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
